// File: rtl/dpram_arb_pkg.sv
// Shared types for the port-A block RAM arbiter:
// requester ids, read-tag bundle, one-hot helper.
package dpram_arb_pkg;

  localparam int REQ_NUM = 3;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_VID = 2'd0;
  localparam req_id_t REQ_CPU = 2'd1;
  localparam req_id_t REQ_DMA = 2'd2;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic logic [REQ_NUM-1:0] id_onehot(
    input req_id_t id
  );
    logic [REQ_NUM-1:0] one;
    one = {{(REQ_NUM-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Requester and RAM port-A bundle of the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface dpram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);

  logic          req0;
  logic          req1;
  logic          req2;
  logic          we0;
  logic          we1;
  logic          we2;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] wdata2;
  logic          gnt0;
  logic          gnt1;
  logic          gnt2;
  logic          rvalid0;
  logic          rvalid1;
  logic          rvalid2;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport slave (
    input  req0, req1, req2,
    input  we0, we1, we2,
    input  addr0, addr1, addr2,
    input  wdata0, wdata1, wdata2,
    input  ram_q,
    output gnt0, gnt1, gnt2,
    output rvalid0, rvalid1, rvalid2,
    output rdata,
    output ram_addr, ram_wdata, ram_wren
  );

  modport master (
    output req0, req1, req2,
    output we0, we1, we2,
    output addr0, addr1, addr2,
    output wdata0, wdata1, wdata2,
    output ram_q,
    input  gnt0, gnt1, gnt2,
    input  rvalid0, rvalid1, rvalid2,
    input  rdata,
    input  ram_addr, ram_wdata, ram_wren
  );

endinterface

// File: rtl/dpram_arb_pick.sv
// Combinational winner pick: video first unless the
// starvation force is up, else round-robin CPU/DMA.
module dpram_arb_pick
  import dpram_arb_pkg::*;
(
  input  logic [REQ_NUM-1:0] req,
  input  req_id_t            rr,
  input  logic               force_rr,
  output logic [REQ_NUM-1:0] gnt,
  output req_id_t            win
);

  logic    any12;
  logic    vid_win;
  logic    rr_win;
  req_id_t rr_id;

  assign any12   = req[REQ_CPU] | req[REQ_DMA];
  assign vid_win = req[REQ_VID] & ~(force_rr & any12);
  assign rr_win  = any12 & ~vid_win;

  // Pick between CPU and DMA; rr only matters on a tie
  always_comb begin
    rr_id = REQ_DMA;
    if (req[REQ_CPU] && req[REQ_DMA]) begin
      rr_id = rr;
    end else if (req[REQ_CPU]) begin
      rr_id = REQ_CPU;
    end
  end

  // One-hot grant and winner id
  always_comb begin
    gnt = '0;
    win = REQ_VID;
    unique case (1'b1)
      vid_win: begin
        gnt = id_onehot(REQ_VID);
        win = REQ_VID;
      end
      rr_win: begin
        gnt = id_onehot(rr_id);
        win = rr_id;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Three-requester arbiter for RAM port A with
// registered command and tagged 2-cycle read return.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW           = 11,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input logic            clk,
  input logic            reset,
  dpram_arbiter_if.slave bus
);

  logic [REQ_NUM-1:0] req;
  logic [REQ_NUM-1:0] gnt;
  req_id_t            win;
  logic               any12;
  logic               force_rr;
  logic               hs;

  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;

  req_id_t       rr_q;
  req_id_t       rr_d;
  logic [7:0]    starve_q;
  logic [7:0]    starve_d;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_q;
  logic [DW-1:0] ram_wdata_d;
  logic          ram_wren_q;
  logic          ram_wren_d;
  rd_tag_t       tag1_q;
  rd_tag_t       tag1_d;
  rd_tag_t       tag2_q;
  rd_tag_t       tag2_d;

  assign req      = {bus.req2, bus.req1, bus.req0};
  assign any12    = bus.req1 | bus.req2;
  assign force_rr = (starve_q == 8'(STARVE_LIMIT));

  dpram_arb_pick u_pick (
    .req      (req),
    .rr       (rr_q),
    .force_rr (force_rr),
    .gnt      (gnt),
    .win      (win)
  );

  // A grant is only ever given to a live request
  assign hs = |gnt;

  // Select the winning requester's command
  always_comb begin
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    win_we    = bus.we0;
    unique case (win)
      REQ_CPU: begin
        win_addr  = bus.addr1;
        win_wdata = bus.wdata1;
        win_we    = bus.we1;
      end
      REQ_DMA: begin
        win_addr  = bus.addr2;
        win_wdata = bus.wdata2;
        win_we    = bus.we2;
      end
      default: ;
    endcase
  end

  // Next state: pointer, starvation count, command, tags
  always_comb begin
    rr_d = rr_q;
    if (gnt[REQ_CPU]) begin
      rr_d = REQ_DMA;
    end else if (gnt[REQ_DMA]) begin
      rr_d = REQ_CPU;
    end

    starve_d = starve_q;
    if (!any12 || gnt[REQ_CPU] || gnt[REQ_DMA]) begin
      starve_d = '0;
    end else if (gnt[REQ_VID]) begin
      starve_d = starve_q + 8'd1;
    end

    ram_addr_d  = hs ? win_addr : ram_addr_q;
    ram_wdata_d = hs ? win_wdata : ram_wdata_q;
    ram_wren_d  = hs & win_we;

    tag1_d.valid = hs & ~win_we;
    tag1_d.id    = win;
    tag2_d       = tag1_q;
  end

  // State registers; reset drops in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= REQ_CPU;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wren_q  <= ram_wren_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  logic [REQ_NUM-1:0] rvalid;

  assign rvalid = tag2_q.valid ? id_onehot(tag2_q.id) : '0;

  assign bus.gnt0      = gnt[REQ_VID];
  assign bus.gnt1      = gnt[REQ_CPU];
  assign bus.gnt2      = gnt[REQ_DMA];
  assign bus.rvalid0   = rvalid[REQ_VID];
  assign bus.rvalid1   = rvalid[REQ_CPU];
  assign bus.rvalid2   = rvalid[REQ_DMA];
  assign bus.rdata     = bus.ram_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed and model-checked bench for dpram_arbiter
// with a 1-cycle registered RAM behind port A.
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_arbiter_if #(.AW(11), .DW(8)) bus ();

  dpram_arbiter #(
    .AW(11),
    .DW(8),
    .STARVE_LIMIT(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ram [0:2047];

  always @(posedge clk) begin
    if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= ram[bus.ram_addr];
  end

  logic [2:0] gnt_v;
  logic [2:0] rv_v;
  logic [2:0] req_v;
  assign gnt_v = {bus.gnt2, bus.gnt1, bus.gnt0};
  assign rv_v  = {bus.rvalid2, bus.rvalid1, bus.rvalid0};
  assign req_v = {bus.req2, bus.req1, bus.req0};

  task automatic clr();
    bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
    bus.we0 = 0; bus.we1 = 0; bus.we2 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr();
    reset = 1;
    #1;
    checks++;
    if (bus.ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_wren got %b want 0", bus.ram_wren);
    end
    checks++;
    if (bus.ram_addr !== 11'h000) begin
      errors++;
      $display("FAIL reset_addr got %h want 000", bus.ram_addr);
    end
    checks++;
    if (bus.ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_wdata got %h want 00", bus.ram_wdata);
    end
    checks++;
    if (rv_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_rvalid got %b want 000", rv_v);
    end
    checks++;
    if (gnt_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_gnt_idle got %b want 000", gnt_v);
    end
    bus.req1 = 1;
    #1;
    checks++;
    if (gnt_v !== 3'b010) begin
      errors++;
      $display("FAIL reset_gnt_comb got %b want 010", gnt_v);
    end
    @(negedge clk);
    clr();
    reset = 0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    clr();
    bus.req2 = 1; bus.we2 = 1;
    bus.addr2 = a; bus.wdata2 = d;
  endtask

  task automatic test_read_stream();
    logic [2:0] eg;
    logic [2:0] er;
    logic [7:0] ed;
    preload(11'h010, 8'hA0);
    preload(11'h011, 8'hA1);
    preload(11'h012, 8'hA2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr();
      if (i < 3) begin
        bus.req1 = 1;
        bus.addr1 = 11'h010 + 11'(i);
      end
      #1;
      eg = (i < 3) ? 3'b010 : 3'b000;
      er = (i >= 2 && i < 5) ? 3'b010 : 3'b000;
      ed = 8'hA0 + 8'(i - 2);
      checks++;
      if (gnt_v !== eg) begin
        errors++;
        $display("FAIL stream_gnt[%0d] got %b want %b", i, gnt_v, eg);
      end
      checks++;
      if (rv_v !== er) begin
        errors++;
        $display("FAIL stream_rvalid[%0d] got %b want %b", i, rv_v, er);
      end
      if (er != 3'b000) begin
        checks++;
        if (bus.rdata !== ed) begin
          errors++;
          $display("FAIL stream_rdata[%0d] got %h want %h", i, bus.rdata, ed);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr();
      bus.req1 = 1; bus.addr1 = 11'h010;
      bus.req2 = 1; bus.addr2 = 11'h011;
      #1;
      eg = (i % 2 == 0) ? 3'b010 : 3'b100;
      checks++;
      if (gnt_v !== eg) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b want %b", i, gnt_v, eg);
      end
    end
    @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_starve();
    logic [2:0] eg;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr();
      bus.req0 = 1; bus.addr0 = 11'h010;
      bus.req1 = 1; bus.addr1 = 11'h011;
      #1;
      eg = (i % 4 == 3) ? 3'b010 : 3'b001;
      checks++;
      if (gnt_v !== eg) begin
        errors++;
        $display("FAIL starve_gnt[%0d] got %b want %b", i, gnt_v, eg);
      end
    end
    @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [2:0] eg;
    logic [2:0] er;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr();
      if (i == 0) begin
        bus.req2 = 1; bus.we2 = 1;
        bus.addr2 = 11'h123; bus.wdata2 = 8'h5C;
      end else if (i == 1) begin
        bus.req1 = 1; bus.addr1 = 11'h123;
      end
      #1;
      eg = (i == 0) ? 3'b100 : (i == 1) ? 3'b010 : 3'b000;
      er = (i == 3) ? 3'b010 : 3'b000;
      checks++;
      if (gnt_v !== eg) begin
        errors++;
        $display("FAIL wr_gnt[%0d] got %b want %b", i, gnt_v, eg);
      end
      checks++;
      if (rv_v !== er) begin
        errors++;
        $display("FAIL wr_rvalid[%0d] got %b want %b", i, rv_v, er);
      end
      if (i == 3) begin
        checks++;
        if (bus.rdata !== 8'h5C) begin
          errors++;
          $display("FAIL wr_rdata got %h want 5c", bus.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_flight();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clr();
      if (i < 2) begin
        bus.req1 = 1;
        bus.addr1 = 11'h010 + 11'(i);
      end
      if (i == 2) reset = 1;
      if (i == 4) reset = 0;
      #1;
      if (i < 2) begin
        checks++;
        if (gnt_v !== 3'b010) begin
          errors++;
          $display("FAIL flight_gnt[%0d] got %b want 010", i, gnt_v);
        end
      end else begin
        checks++;
        if (rv_v !== 3'b000) begin
          errors++;
          $display("FAIL flight_rvalid[%0d] got %b want 000", i, rv_v);
        end
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (bus.ram_wren !== 1'b0) begin
          errors++;
          $display("FAIL flight_wren[%0d] got %b want 0", i, bus.ram_wren);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] mm [0:15];
    logic       pv [3];
    logic       pw [3];
    logic [3:0] pa [3];
    logic [7:0] pd [3];
    req_id_t    m_rr;
    logic [7:0] m_st;
    logic       p1v, p2v;
    req_id_t    p1i, p2i;
    logic [7:0] p1d, p2d;
    logic [2:0] eg;
    logic [2:0] er;
    logic       any12, frc;
    int         pk, g;
    pulse_reset();
    m_rr = REQ_CPU; m_st = '0;
    p1v = 0; p2v = 0; p1i = '0; p2i = '0; p1d = '0; p2d = '0;
    for (int n = 0; n < 3; n++) begin
      pv[n] = 0; pw[n] = 0; pa[n] = '0; pd[n] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (!pv[n]) begin
          if (i < 16) begin
            if (n == 2) begin
              pv[2] = 1; pw[2] = 1;
              pa[2] = 4'(i); pd[2] = 8'(i * 7 + 3);
            end
          end else if ($urandom_range(0, 2) != 0) begin
            pv[n] = 1;
            pw[n] = 1'($urandom_range(0, 1));
            pa[n] = 4'($urandom_range(0, 15));
            pd[n] = 8'($urandom);
          end
        end
      end
      bus.req0 = pv[0]; bus.we0 = pw[0];
      bus.addr0 = {7'h20, pa[0]}; bus.wdata0 = pd[0];
      bus.req1 = pv[1]; bus.we1 = pw[1];
      bus.addr1 = {7'h20, pa[1]}; bus.wdata1 = pd[1];
      bus.req2 = pv[2]; bus.we2 = pw[2];
      bus.addr2 = {7'h20, pa[2]}; bus.wdata2 = pd[2];
      #1;
      any12 = pv[1] | pv[2];
      frc = any12 && (m_st == 8'd3);
      pk = (pv[1] && pv[2]) ? int'(m_rr) : (pv[1] ? 1 : 2);
      g = -1;
      if (pv[0] && !frc) g = 0;
      else if (any12) g = pk;
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      er = p2v ? 3'(1 << p2i) : 3'b000;
      checks++;
      if (gnt_v !== eg) begin
        errors++;
        $display("FAIL rnd_gnt[%0d] got %b want %b", i, gnt_v, eg);
      end
      checks++;
      if ((gnt_v & ~req_v) !== 3'b000) begin
        errors++;
        $display("FAIL rnd_gnt_noreq[%0d] got %b req %b", i, gnt_v, req_v);
      end
      checks++;
      if (rv_v !== er) begin
        errors++;
        $display("FAIL rnd_rvalid[%0d] got %b want %b", i, rv_v, er);
      end
      if (p2v) begin
        checks++;
        if (bus.rdata !== p2d) begin
          errors++;
          $display("FAIL rnd_rdata[%0d] got %h want %h", i, bus.rdata, p2d);
        end
      end
      p2v = p1v; p2i = p1i; p2d = p1d;
      p1v = (g >= 0) && !pw[g >= 0 ? g : 0];
      if (g >= 0) begin
        p1i = 2'(g);
        p1d = mm[pa[g]];
        if (pw[g]) mm[pa[g]] = pd[g];
        pv[g] = 0;
      end
      if (g == 1) m_rr = REQ_DMA;
      else if (g == 2) m_rr = REQ_CPU;
      if (!any12 || g == 1 || g == 2) m_st = '0;
      else if (g == 0) m_st = m_st + 8'd1;
    end
    @(negedge clk);
    clr();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    test_reset();
    test_read_stream();
    test_round_robin();
    test_starve();
    test_write_read();
    test_reset_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
